// File: rtl/cdb_arbiter.sv
//------------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Owns the common data bus (CDB) that broadcasts completed results to the
//   reservation station, load/store buffer and ROB. Two producers (ALU and
//   LSB) each push into a private circular FIFO. The arbiter drains one entry
//   per cycle onto a registered CDB. When both FIFOs hold entries it picks
//   them in round-robin order.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   rdy               global enable; every register holds while low
//   rollback          misprediction flush: empties both FIFOs, drops the CDB
//   alu_valid/rob_id/data, alu_full   ALU push channel and its backpressure
//   lsb_valid/rob_id/data, lsb_full   LSB push channel and its backpressure
//   cdb_valid/rob_id/data/src         registered broadcast (src 0=ALU 1=LSB)
//   ovf_err           sticky flag: a push was attempted into a full FIFO
//------------------------------------------------------------------------------
`ifndef ROB_ID_WID
`define ROB_ID_WID 4
`endif
`ifndef DATA_WID
`define DATA_WID 32
`endif

//------------------------------------------------------------------------------
// cdb_src_fifo
//
// Purpose:
//   Circular FIFO used for one producer. The head entry is read without a
//   clock. full decodes the registered count, so a pop in the same cycle does
//   not free a slot for a push.
//
// Ports:
//   clk, rst, rdy     clock, async reset, global enable
//   flush             empties the FIFO at the next enabled edge
//   push, push_entry  write request and payload (dropped when full)
//   pop               advance the head (ignored when empty)
//   head              entry at the read pointer
//   count             number of stored entries (0..DEPTH)
//   full              count == DEPTH
//------------------------------------------------------------------------------
module cdb_src_fifo #(
   parameter int DEPTH   = 4,
   parameter int PTR_W   = $clog2(DEPTH),
   parameter int ENTRY_W = 36
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               flush,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_entry,
   input  logic               pop,
   output logic [ENTRY_W-1:0] head,
   output logic [PTR_W:0]     count,
   output logic               full
);

   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign push_ok = push && !full;
   assign pop_ok  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   // Pointers and count. DEPTH is a power of two, so the pointers wrap from
   // DEPTH-1 to 0 by ordinary overflow.
   // NOTE: state registers use non-blocking assignments so every register
   // samples the values present before the edge, whatever the statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (rdy) begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // NOTE: the storage array has no reset. The pointers and count define which
   // slots are valid, so stale data is never observed. Leaving it unreset also
   // lets the array map onto plain RAM or flops without reset fan-out.
   always_ff @(posedge clk) begin
      if (rdy && !flush && push_ok) begin
         mem[wr_ptr] <= push_entry;
      end
   end

endmodule

//------------------------------------------------------------------------------
// cdb_arbiter (top)
//------------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   rollback,
   input  logic                   alu_valid,
   input  logic [`ROB_ID_WID-1:0] alu_rob_id,
   input  logic [`DATA_WID-1:0]   alu_data,
   output logic                   alu_full,
   input  logic                   lsb_valid,
   input  logic [`ROB_ID_WID-1:0] lsb_rob_id,
   input  logic [`DATA_WID-1:0]   lsb_data,
   output logic                   lsb_full,
   output logic                   cdb_valid,
   output logic [`ROB_ID_WID-1:0] cdb_rob_id,
   output logic [`DATA_WID-1:0]   cdb_data,
   output logic                   cdb_src,
   output logic                   ovf_err
);

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSB = 1'b1
   } src_e;

   typedef struct packed {
      logic [`ROB_ID_WID-1:0] rob_id;
      logic [`DATA_WID-1:0]   data;
   } cdb_entry_t;

   localparam int ENTRY_W = $bits(cdb_entry_t);

   cdb_entry_t     alu_in;
   cdb_entry_t     lsb_in;
   cdb_entry_t     alu_head;
   cdb_entry_t     lsb_head;
   cdb_entry_t     grant_entry;
   logic [PTR_W:0] alu_count;
   logic [PTR_W:0] lsb_count;
   logic           alu_nonempty;
   logic           lsb_nonempty;
   logic           grant_alu;
   logic           grant_lsb;
   src_e           last_grant;
   src_e           cdb_src_q;

   assign alu_in = '{rob_id: alu_rob_id, data: alu_data};
   assign lsb_in = '{rob_id: lsb_rob_id, data: lsb_data};

   cdb_src_fifo #(
      .DEPTH   (DEPTH),
      .PTR_W   (PTR_W),
      .ENTRY_W (ENTRY_W)
   ) u_alu_fifo (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .flush      (rollback),
      .push       (alu_valid),
      .push_entry (alu_in),
      .pop        (grant_alu),
      .head       (alu_head),
      .count      (alu_count),
      .full       (alu_full)
   );

   cdb_src_fifo #(
      .DEPTH   (DEPTH),
      .PTR_W   (PTR_W),
      .ENTRY_W (ENTRY_W)
   ) u_lsb_fifo (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .flush      (rollback),
      .push       (lsb_valid),
      .push_entry (lsb_in),
      .pop        (grant_lsb),
      .head       (lsb_head),
      .count      (lsb_count),
      .full       (lsb_full)
   );

   assign alu_nonempty = (alu_count != '0);
   assign lsb_nonempty = (lsb_count != '0);

   // Grant comes only from registered counts. A newly pushed entry therefore
   // needs one edge to land in its FIFO before it can win the bus, and there
   // is no input-to-CDB bypass. On a tie the winner is the source that did
   // not win last.
   // NOTE: every signal assigned in this block gets a default first. Otherwise
   // a path that skips the assignment would infer a latch.
   always_comb begin
      grant_alu = 1'b0;
      grant_lsb = 1'b0;
      if (alu_nonempty && lsb_nonempty) begin
         if (last_grant == SRC_LSB) grant_alu = 1'b1;
         else                       grant_lsb = 1'b1;
      end else begin
         grant_alu = alu_nonempty;
         grant_lsb = lsb_nonempty;
      end
   end

   assign grant_entry = grant_lsb ? lsb_head : alu_head;

   // CDB broadcast register, round-robin pointer and sticky overflow flag.
   // When there is no grant, rob_id/data/src keep their last values and only
   // cdb_valid drops.
   // Rollback clears cdb_valid. It leaves last_grant and ovf_err alone, and a
   // push rejected by the flush does not count as an overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_valid  <= 1'b0;
         cdb_rob_id <= '0;
         cdb_data   <= '0;
         cdb_src_q  <= SRC_ALU;
         last_grant <= SRC_LSB;
         ovf_err    <= 1'b0;
      end else if (rdy) begin
         if (rollback) begin
            cdb_valid <= 1'b0;
         end else begin
            if (grant_alu || grant_lsb) begin
               cdb_valid  <= 1'b1;
               cdb_rob_id <= grant_entry.rob_id;
               cdb_data   <= grant_entry.data;
               cdb_src_q  <= grant_lsb ? SRC_LSB : SRC_ALU;
               last_grant <= grant_lsb ? SRC_LSB : SRC_ALU;
            end else begin
               cdb_valid <= 1'b0;
            end
            if ((alu_valid && alu_full) || (lsb_valid && lsb_full)) begin
               ovf_err <= 1'b1;
            end
         end
      end
   end

   assign cdb_src = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
//------------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter. Inputs change 1 time unit after a rising
// edge, and outputs are sampled at that same point.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef ROB_ID_WID
`define ROB_ID_WID 4
`endif
`ifndef DATA_WID
`define DATA_WID 32
`endif

module tb_cdb_arbiter;

   localparam int RW = `ROB_ID_WID;
   localparam int DW = `DATA_WID;

   logic          clk;
   logic          rst;
   logic          rdy;
   logic          rollback;
   logic          alu_valid;
   logic [RW-1:0] alu_rob_id;
   logic [DW-1:0] alu_data;
   logic          alu_full;
   logic          lsb_valid;
   logic [RW-1:0] lsb_rob_id;
   logic [DW-1:0] lsb_data;
   logic          lsb_full;
   logic          cdb_valid;
   logic [RW-1:0] cdb_rob_id;
   logic [DW-1:0] cdb_data;
   logic          cdb_src;
   logic          ovf_err;

   int n_checks;
   int n_fail;
   int alu_seen;
   int lsb_seen;

   cdb_arbiter #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .rollback   (rollback),
      .alu_valid  (alu_valid),
      .alu_rob_id (alu_rob_id),
      .alu_data   (alu_data),
      .alu_full   (alu_full),
      .lsb_valid  (lsb_valid),
      .lsb_rob_id (lsb_rob_id),
      .lsb_data   (lsb_data),
      .lsb_full   (lsb_full),
      .cdb_valid  (cdb_valid),
      .cdb_rob_id (cdb_rob_id),
      .cdb_data   (cdb_data),
      .cdb_src    (cdb_src),
      .ovf_err    (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] cdb_vec();
      return 64'({cdb_valid, cdb_src, cdb_rob_id, cdb_data});
   endfunction

   function automatic logic [63:0] exp_vec(input logic v, input logic s, input int rob, input int data);
      return 64'({v, s, RW'(rob), DW'(data)});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rollback   = 1'b0;
      alu_valid  = 1'b0;
      alu_rob_id = '0;
      alu_data   = '0;
      lsb_valid  = 1'b0;
      lsb_rob_id = '0;
      lsb_data   = '0;
   endtask

   task automatic push_alu(input int rob, input int data);
      alu_valid  = 1'b1;
      alu_rob_id = RW'(rob);
      alu_data   = DW'(data);
   endtask

   task automatic push_lsb(input int rob, input int data);
      lsb_valid  = 1'b1;
      lsb_rob_id = RW'(rob);
      lsb_data   = DW'(data);
   endtask

   task automatic do_reset();
      idle_inputs();
      rdy = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Three simultaneous pushes per source on edges 1..3. The reset tie-break
   // favours the ALU, so after edge 2 the CDB shows ALU 5 and after edge 3 it
   // shows LSB 6.
   task automatic fill3(input string tag);
      push_alu(5, 'hA); push_lsb(6, 'hB);
      tick();
      check({tag, "_e1"}, cdb_vec(), exp_vec(1'b0, 1'b0, 0, 0));
      push_alu(7, 'hC); push_lsb(8, 'hD);
      tick();
      check({tag, "_e2"}, cdb_vec(), exp_vec(1'b1, 1'b0, 5, 'hA));
      push_alu(9, 'hE); push_lsb(10, 'hF);
      tick();
      check({tag, "_e3"}, cdb_vec(), exp_vec(1'b1, 1'b1, 6, 'hB));
      idle_inputs();
   endtask

   // Per-source in-order checker: ALU entries are {i, 0x100+i}, LSB entries
   // are {8+i, 0x200+i}.
   task automatic mon_check();
      if (cdb_valid) begin
         if (cdb_src == 1'b0) begin
            check("t3_alu_order", cdb_vec(), exp_vec(1'b1, 1'b0, alu_seen, 'h100 + alu_seen));
            alu_seen++;
         end else begin
            check("t3_lsb_order", cdb_vec(), exp_vec(1'b1, 1'b1, 8 + lsb_seen, 'h200 + lsb_seen));
            lsb_seen++;
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      rdy      = 1'b1;
      idle_inputs();

      // ---- Test 1: reset state and single ALU push latency -----------------
      do_reset();
      check("rst_cdb",      cdb_vec(), 64'd0);
      check("rst_alu_full", alu_full,  1'b0);
      check("rst_lsb_full", lsb_full,  1'b0);
      check("rst_ovf",      ovf_err,   1'b0);
      push_alu(3, 'h11);
      tick();
      idle_inputs();
      check("t1_e1", cdb_vec(), exp_vec(1'b0, 1'b0, 0, 0));
      tick();
      check("t1_e2", cdb_vec(), exp_vec(1'b1, 1'b0, 3, 'h11));
      tick();
      check("t1_e3_hold", cdb_vec(), exp_vec(1'b0, 1'b0, 3, 'h11));

      // ---- Test 2: round-robin alternation ---------------------------------
      do_reset();
      fill3("t2");
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_rr", cdb_vec(), exp_vec(1'b1, 1'(i % 2), 7 + i, 'hC + i));
      end
      tick();
      check("t2_idle", cdb_valid, 1'b0);

      // ---- Test 3: ALU fills against LSB backlog, overflow -----------------
      do_reset();
      alu_seen = 0;
      lsb_seen = 0;
      for (int e = 1; e <= 8; e++) begin
         push_alu(e - 1, 'h100 + e - 1);
         if (e <= 6) push_lsb(8 + e - 1, 'h200 + e - 1);
         else        lsb_valid = 1'b0;
         tick();
         mon_check();
         if (e == 6) begin
            check("t3_lsb_full_e6", lsb_full, 1'b1);
            check("t3_alu_full_e6", alu_full, 1'b0);
         end
         if (e == 7) begin
            check("t3_alu_full_e7", alu_full, 1'b1);
            check("t3_ovf_e7",      ovf_err,  1'b0);
         end
         if (e == 8) begin
            check("t3_ovf_e8",      ovf_err,  1'b1);
            check("t3_alu_full_e8", alu_full, 1'b0);
         end
      end
      idle_inputs();
      for (int c = 0; c < 12; c++) begin
         tick();
         mon_check();
      end
      check("t3_alu_count", 64'(alu_seen), 64'd7);
      check("t3_lsb_count", 64'(lsb_seen), 64'd6);
      check("t3_ovf_sticky", ovf_err, 1'b1);

      // ---- Test 4: wrap-around with one pop per cycle ----------------------
      do_reset();
      check("t4_ovf_cleared", ovf_err, 1'b0);
      for (int k = 0; k < 10; k++) begin
         push_alu(k, k);
         tick();
         if (k >= 1) check("t4_wrap", cdb_vec(), exp_vec(1'b1, 1'b0, k - 1, k - 1));
         check("t4_no_full", alu_full, 1'b0);
      end
      idle_inputs();
      tick();
      check("t4_last", cdb_vec(), exp_vec(1'b1, 1'b0, 9, 9));
      tick();
      check("t4_idle", cdb_valid, 1'b0);
      check("t4_no_ovf", ovf_err, 1'b0);

      // ---- Test 5: rollback with simultaneous pushes -----------------------
      do_reset();
      fill3("t5");
      rollback = 1'b1;
      push_alu(12, 'h77);
      push_lsb(13, 'h88);
      tick();
      idle_inputs();
      check("t5_rb_valid", cdb_valid, 1'b0);
      check("t5_rb_afull", alu_full,  1'b0);
      tick();
      check("t5_empty1", cdb_valid, 1'b0);
      tick();
      check("t5_empty2", cdb_valid, 1'b0);
      push_alu(1, 'h55);
      tick();
      idle_inputs();
      check("t5_push_e1", cdb_valid, 1'b0);
      tick();
      check("t5_push_e2", cdb_vec(), exp_vec(1'b1, 1'b0, 1, 'h55));
      tick();
      check("t5_push_e3", cdb_valid, 1'b0);

      // ---- Test 6: rdy freeze, resume, async reset mid-drain ---------------
      do_reset();
      fill3("t6");
      rdy = 1'b0;
      push_alu(12, 'h77);
      push_lsb(13, 'h88);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t6_frozen", cdb_vec(), exp_vec(1'b1, 1'b1, 6, 'hB));
      end
      idle_inputs();
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t6_resume", cdb_vec(), exp_vec(1'b1, 1'(i % 2), 7 + i, 'hC + i));
      end
      tick();
      check("t6_idle", cdb_valid, 1'b0);

      do_reset();
      fill3("t6b");
      tick();
      check("t6b_mid", cdb_vec(), exp_vec(1'b1, 1'b0, 7, 'hC));
      rst = 1'b1;
      #1;
      check("t6b_async_cdb",  cdb_vec(), 64'd0);
      check("t6b_async_full", {alu_full, lsb_full}, 2'b00);
      #1;
      rst = 1'b0;
      tick();
      check("t6b_discard1", cdb_valid, 1'b0);
      tick();
      check("t6b_discard2", cdb_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
